// File: rtl/feature_spi_tx.sv
// feature_spi_tx: queues pooled CNN feature vectors in a small FIFO and
// streams each one out as a single SPI mode-0 frame, element 0 first, MSB first.
module feature_spi_tx #(
  parameter int NUM_CH     = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SCLK_DIV   = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_feature_valid,
  input  logic signed [NUM_CH-1:0][DATA_W-1:0] i_features,
  output logic                                o_ready,
  output logic                                o_sclk,
  output logic                                o_cs_n,
  output logic                                o_mosi,
  output logic                                o_busy,
  output logic                                o_overflow
);

  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GAP_W   = $clog2(2 * SCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [FRAME_W-1:0] push_word;
  logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;
  logic               fifo_empty;

  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   rise_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  // Ready comes only from the registered count, so a same-cycle pop never
  // opens a slot for a push into a full FIFO.
  assign fifo_empty = (count == '0);
  assign o_ready    = (count != CNT_W'(FIFO_DEPTH));
  assign push       = i_feature_valid && o_ready;
  assign pop        = (state == S_LOAD);
  assign o_busy     = (state != S_IDLE) || !fifo_empty;

  // Flatten the vector so element 0 lands in the MSBs and goes out first.
  always_comb begin
    push_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push_word[FRAME_W-1-k*DATA_W -: DATA_W] = i_features[k];
    end
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
    end else if (i_feature_valid && !o_ready) begin
      o_overflow <= 1'b1;
    end
  end

  // Frame sequencer; the GAP state runs one cycle short so that, together
  // with the LOAD cycle, chip select idles high for 2*SCLK_DIV cycles
  // between back-to-back frames.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      div_cnt  <= '0;
      rise_cnt <= '0;
      gap_cnt  <= '0;
      o_sclk   <= 1'b0;
      o_cs_n   <= 1'b1;
      o_mosi   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg    <= fifo_mem[rd_ptr];
          o_mosi   <= fifo_mem[rd_ptr][FRAME_W-1];
          o_cs_n   <= 1'b0;
          o_sclk   <= 1'b0;
          div_cnt  <= '0;
          rise_cnt <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!o_sclk) begin
              o_sclk   <= 1'b1;
              rise_cnt <= rise_cnt + BIT_W'(1);
            end else begin
              o_sclk <= 1'b0;
              if (rise_cnt == BIT_W'(FRAME_W)) begin
                o_cs_n  <= 1'b1;
                o_mosi  <= 1'b0;
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                shreg  <= shreg << 1;
                o_mosi <= shreg[FRAME_W-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(2 * SCLK_DIV - 2)) begin
            state <= fifo_empty ? S_IDLE : S_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_spi_tx.sv
// tb_feature_spi_tx: directed vector table plus hand-written multi-cycle
// sequences for latency, back-to-back frames, overflow, mid-frame reset and
// push-during-pop.
module tb_feature_spi_tx;

  logic                   i_clk;
  logic                   i_rst_n;
  logic                   i_feature_valid;
  logic signed [5:0][7:0] i_features;
  logic                   o_ready;
  logic                   o_sclk;
  logic                   o_cs_n;
  logic                   o_mosi;
  logic                   o_busy;
  logic                   o_overflow;

  typedef struct {
    logic [47:0] bits;
    int          len;
    int          rises;
  } frame_t;

  typedef struct {
    logic [47:0] feat;
    logic [47:0] exp_bits;
    int          exp_len;
    int          exp_rises;
  } vec_t;

  frame_t      frames [$];
  int          gaps [$];
  int          cur_rises;
  int          checks;
  int          errors;
  vec_t        vectors [5];
  logic [47:0] seq_v [6];

  feature_spi_tx #(
    .NUM_CH(6), .DATA_W(8), .FIFO_DEPTH(4), .SCLK_DIV(2)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_feature_valid(i_feature_valid),
    .i_features(i_features),
    .o_ready(o_ready),
    .o_sclk(o_sclk),
    .o_cs_n(o_cs_n),
    .o_mosi(o_mosi),
    .o_busy(o_busy),
    .o_overflow(o_overflow)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Serial monitor: rebuilds each frame from the bits seen on o_sclk rises.
  initial begin
    logic [47:0] cur_bits;
    int          cur_len;
    int          high_cnt;
    logic        prev_sclk;
    logic        prev_cs_n;
    logic        have_prev;
    frame_t      f;
    cur_bits = '0; cur_len = 0; cur_rises = 0; high_cnt = 0;
    prev_sclk = 1'b0; prev_cs_n = 1'b1; have_prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        cur_bits = '0; cur_len = 0; cur_rises = 0; high_cnt = 0;
        prev_sclk = 1'b0; prev_cs_n = 1'b1; have_prev = 1'b0;
        frames.delete();
        gaps.delete();
      end else begin
        if (!o_cs_n) begin
          if (prev_cs_n) begin
            if (have_prev) gaps.push_back(high_cnt);
            cur_bits = '0; cur_len = 0; cur_rises = 0;
          end
          cur_len++;
          if (o_sclk && !prev_sclk) begin
            cur_bits = {cur_bits[46:0], o_mosi};
            cur_rises++;
          end
        end else begin
          if (!prev_cs_n) begin
            f.bits = cur_bits; f.len = cur_len; f.rises = cur_rises;
            frames.push_back(f);
            have_prev = 1'b1;
            high_cnt = 0;
          end
          high_cnt++;
        end
        prev_sclk = o_sclk;
        prev_cs_n = o_cs_n;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of input on the negative edge, ahead of the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [47:0] feat_msb_first);
    @(negedge i_clk);
    i_feature_valid = valid;
    for (int k = 0; k < 6; k++) begin
      i_features[k] = feat_msb_first[47-8*k -: 8];
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (frames.size() < n && c < budget) begin
      @(negedge i_clk);
      c++;
    end
    checkOutput("frames_seen", (frames.size() >= n) ? n : frames.size(), n);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_feature_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic check_frame(input string name, input int idx, input logic [47:0] exp_bits);
    if (idx < frames.size()) begin
      checkOutput({name, "_bits"}, frames[idx].bits, exp_bits);
      checkOutput({name, "_len"}, frames[idx].len, 192);
      checkOutput({name, "_rises"}, frames[idx].rises, 48);
    end else begin
      checkOutput({name, "_present"}, frames.size(), idx + 1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    i_rst_n = 1'b0;
    i_feature_valid = 1'b0;
    i_features = '0;

    vectors[0] = '{48'h123456789ABC, 48'h123456789ABC, 192, 48};
    vectors[1] = '{48'h80FF007F01FE, 48'h80FF007F01FE, 192, 48};
    vectors[2] = '{48'h000000000000, 48'h000000000000, 192, 48};
    vectors[3] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 192, 48};
    vectors[4] = '{48'hA55AC33C0FF0, 48'hA55AC33C0FF0, 192, 48};

    seq_v[0] = 48'hA1A2A3A4A5A6;
    seq_v[1] = 48'hB1B2B3B4B5B6;
    seq_v[2] = 48'hC1C2C3C4C5C6;
    seq_v[3] = 48'hD1D2D3D4D5D6;
    seq_v[4] = 48'hE1E2E3E4E5E6;
    seq_v[5] = 48'hF1F2F3F4F5F6;

    // Outputs while reset is held
    repeat (2) @(negedge i_clk);
    checkOutput("rst_cs_n", o_cs_n, 1);
    checkOutput("rst_sclk", o_sclk, 0);
    checkOutput("rst_mosi", o_mosi, 0);
    checkOutput("rst_overflow", o_overflow, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_ready", o_ready, 1);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Latency: accepted at edge N, chip select low at edge N+2
    applyStimulus(1'b1, 48'h123456789ABC);
    @(negedge i_clk);
    i_feature_valid = 1'b0;
    checkOutput("lat_cs_n_N", o_cs_n, 1);
    checkOutput("lat_busy_N", o_busy, 1);
    @(negedge i_clk);
    checkOutput("lat_cs_n_N1", o_cs_n, 1);
    @(negedge i_clk);
    checkOutput("lat_cs_n_N2", o_cs_n, 0);
    wait_frames(1, 400);
    check_frame("lat_frame", 0, 48'h123456789ABC);

    // Table of single-vector frames
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vectors[i].feat);
      applyStimulus(1'b0, '0);
      wait_frames(i + 1, 400);
      if (i < frames.size()) begin
        checkOutput("tbl_bits", frames[i].bits, vectors[i].exp_bits);
        checkOutput("tbl_len", frames[i].len, vectors[i].exp_len);
        checkOutput("tbl_rises", frames[i].rises, vectors[i].exp_rises);
      end
    end

    // Five back-to-back vectors: all accepted, sent in order, 4-cycle gaps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, seq_v[i]);
      checkOutput("b2b_ready", o_ready, 1);
    end
    applyStimulus(1'b0, '0);
    checkOutput("b2b_overflow", o_overflow, 0);
    wait_frames(5, 1500);
    for (int i = 0; i < 5; i++) check_frame("b2b_frame", i, seq_v[i]);
    for (int i = 0; i < 4; i++) begin
      if (i < gaps.size()) checkOutput("b2b_gap", gaps[i], 4);
      else checkOutput("b2b_gap_present", gaps.size(), i + 1);
    end
    checkOutput("b2b_overflow_end", o_overflow, 0);

    // Six consecutive vectors: the sixth finds the FIFO full and is dropped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, seq_v[i]);
      checkOutput("ovf_ready", o_ready, (i == 5) ? 1'b0 : 1'b1);
      if (i == 5) checkOutput("ovf_flag_before", o_overflow, 0);
    end
    applyStimulus(1'b0, '0);
    checkOutput("ovf_flag_set", o_overflow, 1);
    wait_frames(5, 1500);
    repeat (300) @(negedge i_clk);
    checkOutput("ovf_frame_total", frames.size(), 5);
    for (int i = 0; i < 5; i++) check_frame("ovf_frame", i, seq_v[i]);
    checkOutput("ovf_flag_sticky", o_overflow, 1);

    // Push on the LOAD edge with three vectors queued
    do_reset();
    applyStimulus(1'b1, seq_v[0]);
    applyStimulus(1'b0, '0);
    begin
      int c;
      c = 0;
      while (o_cs_n && c < 20) begin @(negedge i_clk); c++; end
      checkOutput("pp_frame_started", o_cs_n, 0);
      for (int i = 1; i < 4; i++) applyStimulus(1'b1, seq_v[i]);
      applyStimulus(1'b0, '0);
      c = 0;
      while (!o_cs_n && c < 400) begin @(negedge i_clk); c++; end
      checkOutput("pp_frame_ended", o_cs_n, 1);
    end
    repeat (2) @(negedge i_clk);
    applyStimulus(1'b1, seq_v[4]);
    checkOutput("pp_ready_before", o_ready, 1);
    applyStimulus(1'b0, '0);
    checkOutput("pp_load_cs_n", o_cs_n, 0);
    checkOutput("pp_ready_after", o_ready, 1);
    wait_frames(5, 1500);
    for (int i = 0; i < 5; i++) check_frame("pp_frame", i, seq_v[i]);
    checkOutput("pp_overflow", o_overflow, 0);

    // Reset pulsed mid-frame with two vectors queued
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, seq_v[i]);
    applyStimulus(1'b0, '0);
    begin
      int c;
      c = 0;
      while (cur_rises < 20 && c < 400) begin @(negedge i_clk); c++; end
      checkOutput("ra_reached_bit20", (cur_rises >= 20) ? 1 : 0, 1);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("ra_cs_n", o_cs_n, 1);
    checkOutput("ra_sclk", o_sclk, 0);
    checkOutput("ra_mosi", o_mosi, 0);
    checkOutput("ra_busy", o_busy, 0);
    checkOutput("ra_ready", o_ready, 1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (600) @(negedge i_clk);
    checkOutput("ra_no_frame", frames.size(), 0);
    checkOutput("ra_cs_n_idle", o_cs_n, 1);
    applyStimulus(1'b1, 48'h0F1E2D3C4B5A);
    applyStimulus(1'b0, '0);
    wait_frames(1, 400);
    check_frame("ra_new_frame", 0, 48'h0F1E2D3C4B5A);
    repeat (300) @(negedge i_clk);
    checkOutput("ra_one_frame", frames.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
